// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid_reg #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_skid_reg: WIDTH and CNT_W must be at least 1");
  end

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;
  logic             acc, drn;

  assign acc = in_valid & in_ready_q;
  assign drn = main_v_q & out_ready;

  always_comb begin
    main_v_d   = main_v_q;
    skid_v_d   = skid_v_q;
    out_data_d = out_data_q;
    skid_d_d   = skid_d_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (acc) begin
        main_v_d   = 1'b1;
        out_data_d = in_data;
      end
    end else if (drn) begin
      if (skid_v_q) begin
        // in_ready is low while the skid is full, so no accept can coincide
        out_data_d = skid_d_q;
        skid_v_d   = 1'b0;
      end else if (acc) begin
        out_data_d = in_data;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (acc) begin
      skid_d_d = in_data;
      skid_v_d = 1'b1;
    end
    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
      out_data_q <= RESET_DATA;
      skid_d_q   <= RESET_DATA;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
      out_data_q <= out_data_d;
      skid_d_q   <= skid_d_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_data  = out_data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; clear wins over increment, flush has no effect
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (main_v_q && !out_ready && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (!main_v_q && bubble_cnt_q != '1)
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: directed scenarios then a random handshake soak.
module tb_pipe_stage_skid_reg;
  localparam int               W     = 8;
  localparam int               CW    = 4;
  localparam logic [W-1:0]     RDATA = 8'h5A;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         cnt_clr = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];
  int occ = 0;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.WIDTH(W), .RESET_DATA(RDATA), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One clock of stimulus; the expected word is queued when the stage accepts it.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(negedge clk);
    if (rst_n && v && in_ready && !f) sb.push_back(d);
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every downstream transfer and tracks occupancy independently.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      occ = 0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (in_ready !== (occ < 2) || out_valid !== (occ > 0)) begin
        errors++;
        $display("FAIL occupancy: in_ready=%b out_valid=%b expected occ=%0d", in_ready, out_valid, occ);
      end
      if (prev_stall && out_valid) begin
        checks++;
        if (out_data !== prev_data) begin
          errors++;
          $display("FAIL hold: out_data=%0h expected %0h", out_data, prev_data);
        end
      end
      if (in_valid && in_ready && occ >= 2) begin
        errors++;
        $display("FAIL accept_full: accept with occupancy %0d", occ);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL deliver: got %0h with empty scoreboard", out_data);
        end else begin
          logic [W-1:0] exp_d;
          exp_d = sb.pop_front();
          if (out_data !== exp_d) begin
            errors++;
            $display("FAIL deliver: got %0h expected %0h", out_data, exp_d);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (flush) begin
        sb.delete();
        occ = 0;
      end else begin
        occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      end
    end
  end

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_data", 32'(out_data), 32'(RDATA));

    // Streaming at full rate
    cyc(1, 8'h11, 1, 0);
    check("stream_first", 32'(out_data), 32'h11);
    cyc(1, 8'h22, 1, 0);
    check("stream_second", 32'(out_data), 32'h22);
    cyc(1, 8'h33, 1, 0);
    check("stream_third", 32'(out_data), 32'h33);
    check("stream_in_ready", 32'(in_ready), 32'd1);
    cyc(0, 8'h00, 1, 0);
    check("stream_empty", 32'(out_valid), 32'd0);

    // Backpressure into the skid entry
    cyc(1, 8'hA1, 0, 0);
    check("skid_main", 32'(out_data), 32'hA1);
    cyc(1, 8'hA2, 0, 0);
    check("skid_in_ready_low", 32'(in_ready), 32'd0);
    check("skid_hold", 32'(out_data), 32'hA1);
    cyc(1, 8'hB0, 0, 0);
    check("skid_no_accept", 32'(out_data), 32'hA1);
    cyc(0, 8'h00, 1, 0);
    check("skid_second_out", 32'(out_data), 32'hA2);
    check("skid_in_ready_back", 32'(in_ready), 32'd1);
    cyc(0, 8'h00, 1, 0);
    check("skid_drained", 32'(out_valid), 32'd0);

    // Flush with two entries held and a new word offered
    cyc(1, 8'hC1, 0, 0);
    cyc(1, 8'hC2, 0, 0);
    cyc(1, 8'hFF, 0, 1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    cyc(0, 8'h00, 1, 0);
    check("flush_no_ff", 32'(out_valid), 32'd0);

    // Flush coinciding with a downstream transfer
    cyc(1, 8'hD1, 0, 0);
    cyc(1, 8'hD2, 1, 1);
    check("flush_drn", 32'(out_valid), 32'd0);

    // Asynchronous reset while holding entries
    cyc(1, 8'hE1, 0, 0);
    cyc(1, 8'hE2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_out_data", 32'(out_data), 32'(RDATA));
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef PIPE_STAGE_PERF_EN
    cnt_clr = 1'b1;
    cyc(1, 8'h77, 0, 0);
    cnt_clr = 1'b0;
    check("perf_cleared", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 20; i++) cyc(0, 8'h00, 0, 0);
    check("perf_stall_sat", 32'(stall_cnt), 32'd15);
    check("perf_bubble", 32'(bubble_cnt), 32'd0);
    cnt_clr = 1'b1;
    cyc(0, 8'h00, 0, 0);
    cnt_clr = 1'b0;
    check("perf_clr", 32'(stall_cnt), 32'd0);
    cyc(0, 8'h00, 1, 0);
`endif

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc(0, 8'h00, 1, 0);
    check("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
